adxl362_spi_master: RTL and testbench
=====================================

Name: adxl362_spi_master

Overview:
- FPGA-side SPI master that issues ADXL362 transactions on the PmodACL2 bus: command byte, address byte, then 0..255 data bytes.
- Sits directly upstream of the ADXL362 SPI slave model. Drives SCLK/MOSI/nCS and samples MISO.
- Mode is fixed at CPOL=0, CPHA=0, MSB first.
- User side is a byte-level start/ack/valid handshake used by the accelerometer controller.

Parameters:
- CLK_DIV, 4, clk_16mhz cycles per SCLK half-period. Minimum 2. The default gives 2 MHz SCLK.
- CS_SETUP, 2, cycles nCS is low before the first SCLK rising edge work begins.
- CS_HOLD, 2, cycles nCS stays low after the last SCLK falling edge.
- CS_IDLE, 4, minimum cycles nCS is high between transactions.

Ports:
- clk_16mhz  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a transaction; accepted only in IDLE
- command  in  8  0x0A write, 0x0B read, 0x0D FIFO read; latched at accept
- address  in  8  register address; latched at accept
- byte_count  in  8  number of data bytes after the address; latched at accept
- tx_data  in  8  data byte to shift out; sampled in the cycle tx_ack is high
- tx_ack  out  1  one-cycle pulse: tx_data consumed for the current data byte
- rx_data  out  8  last received data byte; held until the next rx_valid
- rx_valid  out  1  one-cycle pulse: rx_data updated
- busy  out  1  high from accept until return to IDLE
- done  out  1  one-cycle pulse on the cycle the FSM re-enters IDLE
- SCLK  out  1  SPI clock; idles low
- MOSI  out  1  SPI data out
- nCS  out  1  chip select, active low
- MISO  in  1  SPI data in

Behaviour:
- Reset (asynchronous, any state): nCS=1, SCLK=0, MOSI=0, tx_ack=0, rx_valid=0, rx_data=0, busy=0, done=0, FSM=IDLE, all counters cleared.
  - Reset mid-transaction aborts immediately: no done pulse, no rx_valid.
- IDLE: nCS=1, SCLK=0.
  - start=1 latches command, address and byte_count, sets busy, goes to SETUP.
  - start while busy is ignored; no queuing.
- SETUP: nCS=0 for CS_SETUP cycles, then LOAD with byte index 0.
- LOAD (1 cycle, SCLK=0): selects the byte to send.
  - Index 0 sends command; index 1 sends address; index k>=2 sends tx_data, with tx_ack=1 in this cycle.
  - MOSI is set to bit 7 of the selected byte. Then go to SHIFT.
- SHIFT, per bit:
  - SCLK low for CLK_DIV cycles, then rises; MISO is sampled into the rx shift register on the cycle SCLK goes high.
  - SCLK high for CLK_DIV cycles, then falls; MOSI advances to the next bit on the falling transition.
  - After the 8th high phase SCLK returns low and the byte is complete.
  - Byte time: 1 + 16*CLK_DIV cycles including LOAD.
- Byte complete:
  - Index >= 2: rx_data takes the shifted byte and rx_valid pulses 1 cycle.
  - Bytes received at index 0 and 1 are discarded.
  - If index < 1 + byte_count, increment the index and go to LOAD; else go to HOLD.
- HOLD: SCLK=0, nCS=0 for CS_HOLD cycles, then GAP.
- GAP: nCS=1 for CS_IDLE cycles, then IDLE with done=1 and busy=0 in that cycle.
- Total busy length: 1 + CS_SETUP + (2+byte_count)*(1+16*CLK_DIV) + CS_HOLD + CS_IDLE cycles.
  - With defaults and byte_count=1: 1+2+3*65+2+4 = 204 cycles.
- byte_count=0: command and address only; no tx_ack, no rx_valid.
- byte_count=255: 257 bytes total; the 8-bit index is widened to 9 bits so there is no wrap.
- For reads, MOSI carries tx_data during the data phase; the controller drives 0x00.
- nCS never toggles within a transaction.
- SCLK is never high while nCS=1.

Test Plan:
- Register write: start with command=0x0A, address=0x2D, byte_count=1, tx_data=0x02 → MOSI bytes 0x0A,0x2D,0x02; one tx_ack; slave model write=1 with address 0x2D, data 0x02; done after 204 cycles.
- Single read: command=0x0B, address=0x00, byte_count=1 → slave returns DEVID 0xAD; exactly one rx_valid with rx_data=0xAD; SCLK period measured as 8 clk_16mhz cycles.
- Burst read: command=0x0B, address=0x0E, byte_count=6 → six rx_valid pulses with data for addresses 0x0E..0x13 in order; six tx_ack pulses; nCS low continuously throughout.
- Busy rejection: assert start again mid-transaction with a different address → ignored; only one done pulse; bus bytes match the first request.
- Reset mid-transaction: pull reset_n low during address bit 4 → same cycle nCS=1, SCLK=0, busy=0, no done; the next transaction completes correctly.
- Zero-length: byte_count=0 → 2 bytes on the bus, no tx_ack, no rx_valid, done after 1+2+2*65+2+4 = 139 cycles.

Source files
------------

// File: rtl/adxl362_spi_master.sv
// SPI master (CPOL=0, CPHA=0, MSB first) for ADXL362 transactions:
// command byte, address byte, then 0..255 data bytes under one nCS assertion.
module adxl362_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk_16mhz,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] command,
    input  logic [7:0] address,
    input  logic [7:0] byte_count,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       MOSI,
    output logic       nCS,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_END  = 16'(CS_IDLE - 1);

    state_t      state;
    logic [7:0]  cmd_q;
    logic [7:0]  addr_q;
    logic [7:0]  count_q;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [8:0]  index;   // 9 bits so byte_count=255 (257 bytes) cannot wrap
    logic [2:0]  bit_cnt;
    logic [15:0] timer;
    logic [7:0]  sel_byte;
    logic        last_byte;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        sel_byte = tx_data;
        if (index == 9'd0)
            sel_byte = cmd_q;
        else if (index == 9'd1)
            sel_byte = addr_q;
    end

    assign last_byte = (index == ({1'b0, count_q} + 9'd1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            count_q  <= 8'h00;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            index    <= 9'd0;
            bit_cnt  <= 3'd0;
            timer    <= 16'd0;
            tx_ack   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            nCS      <= 1'b1;
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    nCS  <= 1'b1;
                    SCLK <= 1'b0;
                    if (start) begin
                        cmd_q   <= command;
                        addr_q  <= address;
                        count_q <= byte_count;
                        busy    <= 1'b1;
                        nCS     <= 1'b0;
                        timer   <= 16'd0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (timer == SETUP_END) begin
                        timer <= 16'd0;
                        index <= 9'd0;
                        state <= S_LOAD;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_LOAD: begin
                    tx_sr   <= sel_byte;
                    MOSI    <= sel_byte[7];
                    timer   <= 16'd0;
                    bit_cnt <= 3'd0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (timer != DIV_END) begin
                        timer <= timer + 16'd1;
                    end else begin
                        timer <= 16'd0;
                        if (!SCLK) begin
                            SCLK  <= 1'b1;
                            rx_sr <= {rx_sr[6:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                MOSI    <= tx_sr[6];
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                            end else begin
                                if (index >= 9'd2) begin
                                    rx_data  <= rx_sr;
                                    rx_valid <= 1'b1;
                                end
                                if (!last_byte) begin
                                    // The next LOAD carries a data byte once the address has gone out
                                    index  <= index + 9'd1;
                                    tx_ack <= (index != 9'd0);
                                    state  <= S_LOAD;
                                end else begin
                                    state <= S_HOLD;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    SCLK <= 1'b0;
                    if (timer == HOLD_END) begin
                        timer <= 16'd0;
                        nCS   <= 1'b1;
                        state <= S_GAP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_GAP: begin
                    if (timer == IDLE_END) begin
                        timer <= 16'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master with a behavioural ADXL362 slave
// (register write, reads, burst, busy rejection, reset abort, zero length).
module tb_adxl362_spi_master;

    logic       clk_16mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] command   = 8'h00;
    logic [7:0] address   = 8'h00;
    logic [7:0] byte_count = 8'h00;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       MOSI;
    logic       nCS;
    logic       MISO;

    adxl362_spi_master dut (
        .clk_16mhz (clk_16mhz),
        .reset_n   (reset_n),
        .start     (start),
        .command   (command),
        .address   (address),
        .byte_count(byte_count),
        .tx_data   (tx_data),
        .tx_ack    (tx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .nCS       (nCS),
        .MISO      (MISO)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus monitors, sampled on the falling clock edge
    int         cyc = 0;
    int         ack_cnt = 0, rxv_cnt = 0, done_cnt = 0, ncs_fall_cnt = 0, sclk_bad_cnt = 0;
    logic       prev_ncs = 1'b1;
    logic [7:0] rx_q[$];
    int         rise_q[$];

    always @(posedge clk_16mhz) cyc++;

    always @(negedge clk_16mhz) begin
        if (tx_ack)   ack_cnt++;
        if (done)     done_cnt++;
        if (rx_valid) begin
            rxv_cnt++;
            rx_q.push_back(rx_data);
        end
        if (prev_ncs && !nCS) ncs_fall_cnt++;
        if (SCLK && nCS) sclk_bad_cnt++;
        prev_ncs = nCS;
    end

    always @(posedge SCLK) rise_q.push_back(cyc);

    // Behavioural ADXL362 slave: 0x0A writes, 0x0B reads with auto-increment
    logic [7:0] mem [256];
    logic [7:0] bus_q[$];
    int         s_bitc = 0, s_idx = 0;
    logic [7:0] s_cmd = 8'h00, s_addr = 8'h00, s_mosi_sr = 8'h00, s_miso_sr = 8'h00, s_next = 8'h00;
    logic       s_wr_seen = 1'b0;
    logic [7:0] s_wr_addr = 8'h00, s_wr_data = 8'h00;

    assign MISO = s_miso_sr[7];

    always @(negedge nCS) begin
        s_bitc    = 0;
        s_idx     = 0;
        s_miso_sr = 8'h00;
        s_next    = 8'h00;
        bus_q.delete();
    end

    always @(posedge SCLK) begin
        if (!nCS) begin
            s_mosi_sr = {s_mosi_sr[6:0], MOSI};
            s_bitc++;
            if (s_bitc == 8) begin
                s_bitc = 0;
                bus_q.push_back(s_mosi_sr);
                if (s_idx == 0) begin
                    s_cmd = s_mosi_sr;
                end else if (s_idx == 1) begin
                    s_addr = s_mosi_sr;
                end else if (s_cmd == 8'h0A) begin
                    mem[s_addr] = s_mosi_sr;
                    s_wr_seen = 1'b1;
                    s_wr_addr = s_addr;
                    s_wr_data = s_mosi_sr;
                    s_addr++;
                end else begin
                    s_addr++;
                end
                s_next = (s_idx >= 1 && s_cmd != 8'h0A) ? mem[s_addr] : 8'h00;
                s_idx++;
            end
        end
    end

    always @(negedge SCLK) begin
        if (!nCS) begin
            if (s_bitc == 0) s_miso_sr = s_next;
            else             s_miso_sr = {s_miso_sr[6:0], 1'b0};
        end
    end

    // Results of the most recent run_txn
    int   r_len, r_ack, r_rxv, r_done, r_fall, rxq0, rise0;
    logic r_done_now;

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] adr,
                           input logic [7:0] bc, input logic [7:0] txd, input int rej_at);
        int ack0, rxv0, done0, fall0;
        logic timeout;
        @(negedge clk_16mhz);
        command = cmd; address = adr; byte_count = bc; tx_data = txd; start = 1'b1;
        ack0 = ack_cnt; rxv0 = rxv_cnt; done0 = done_cnt; fall0 = ncs_fall_cnt;
        rxq0 = rx_q.size(); rise0 = rise_q.size();
        @(posedge clk_16mhz); #1;
        start = 1'b0;
        r_len = 1;
        timeout = 1'b0;
        while (busy) begin
            if (r_len >= 20000) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk_16mhz); #1;
            r_len++;
            if (r_len == rej_at) begin
                start = 1'b1; address = 8'h05;
            end else if (r_len == rej_at + 1) begin
                start = 1'b0; address = adr;
            end
        end
        r_done_now = done;
        repeat (3) @(posedge clk_16mhz);
        #1;
        r_ack  = ack_cnt - ack0;
        r_rxv  = rxv_cnt - rxv0;
        r_done = done_cnt - done0;
        r_fall = ncs_fall_cnt - fall0;
        n_checks++;
        if (timeout) begin
            n_fail++;
            $display("FAIL txn_timeout: busy still %b after %0d cycles, required 0", busy, r_len);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_16mhz);
        #1;
        n_checks++;
        if ({nCS, SCLK, MOSI, tx_ack, rx_valid, busy, done} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: nCS,SCLK,MOSI,tx_ack,rx_valid,busy,done=%b required 1000000",
                     {nCS, SCLK, MOSI, tx_ack, rx_valid, busy, done});
        end
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        @(negedge clk_16mhz);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_16mhz);
    endtask

    task automatic test_register_write();
        run_txn(8'h0A, 8'h2D, 8'h01, 8'h02, -1);
        n_checks++;
        if (r_len !== 204) begin
            n_fail++; $display("FAIL write_length: got %0d cycles required 204", r_len);
        end
        n_checks++;
        if (bus_q.size() !== 3 || bus_q[0] !== 8'h0A || bus_q[1] !== 8'h2D || bus_q[2] !== 8'h02) begin
            n_fail++; $display("FAIL write_bytes: got %p required 0a 2d 02", bus_q);
        end
        n_checks++;
        if (r_ack !== 1) begin
            n_fail++; $display("FAIL write_tx_ack: got %0d pulses required 1", r_ack);
        end
        n_checks++;
        if (s_wr_seen !== 1'b1 || s_wr_addr !== 8'h2D || s_wr_data !== 8'h02) begin
            n_fail++; $display("FAIL write_slave: seen=%b addr=%h data=%h required 1 2d 02",
                               s_wr_seen, s_wr_addr, s_wr_data);
        end
        n_checks++;
        if (r_done_now !== 1'b1 || r_done !== 1) begin
            n_fail++; $display("FAIL write_done: at_idle=%b pulses=%0d required 1 1", r_done_now, r_done);
        end
    endtask

    task automatic test_single_read();
        run_txn(8'h0B, 8'h00, 8'h01, 8'h00, -1);
        n_checks++;
        if (r_rxv !== 1 || rx_q[rxq0] !== 8'hAD) begin
            n_fail++; $display("FAIL read_devid: pulses=%0d data=%h required 1 ad", r_rxv, rx_q[rxq0]);
        end
        n_checks++;
        if (rise_q[rise0 + 2] - rise_q[rise0 + 1] !== 8) begin
            n_fail++; $display("FAIL read_sclk_period: got %0d cycles required 8",
                               rise_q[rise0 + 2] - rise_q[rise0 + 1]);
        end
        n_checks++;
        if (r_len !== 204) begin
            n_fail++; $display("FAIL read_length: got %0d cycles required 204", r_len);
        end
    endtask

    task automatic test_burst_read();
        logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_txn(8'h0B, 8'h0E, 8'h06, 8'h00, -1);
        n_checks++;
        if (r_rxv !== 6 || r_ack !== 6) begin
            n_fail++; $display("FAIL burst_counts: rx_valid=%0d tx_ack=%0d required 6 6", r_rxv, r_ack);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rx_q[rxq0 + i] !== exp[i]) begin
                n_fail++; $display("FAIL burst_data[%0d]: got %h required %h", i, rx_q[rxq0 + i], exp[i]);
            end
        end
        n_checks++;
        if (r_fall !== 1 || r_len !== 529) begin
            n_fail++; $display("FAIL burst_ncs_len: ncs_falls=%0d len=%0d required 1 529", r_fall, r_len);
        end
    endtask

    task automatic test_busy_reject();
        run_txn(8'h0B, 8'h00, 8'h01, 8'h00, 50);
        n_checks++;
        if (bus_q.size() !== 3 || bus_q[0] !== 8'h0B || bus_q[1] !== 8'h00 || bus_q[2] !== 8'h00) begin
            n_fail++; $display("FAIL reject_bytes: got %p required 0b 00 00", bus_q);
        end
        n_checks++;
        if (r_done !== 1 || r_fall !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reject_single: done=%0d ncs_falls=%0d busy=%b required 1 1 0",
                               r_done, r_fall, busy);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int done0, rxv0;
        @(negedge clk_16mhz);
        command = 8'h0B; address = 8'hF0; byte_count = 8'h02; tx_data = 8'h00; start = 1'b1;
        @(negedge clk_16mhz);
        start = 1'b0;
        while (!(s_idx == 1 && s_bitc == 4) && guard < 5000) begin
            @(negedge clk_16mhz);
            guard++;
        end
        n_checks++;
        if (guard >= 5000) begin
            n_fail++; $display("FAIL abort_reach_bit4: slave idx=%0d bit=%0d required 1 4", s_idx, s_bitc);
        end
        done0 = done_cnt; rxv0 = rxv_cnt;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({nCS, SCLK, busy, done} !== 4'b1000) begin
            n_fail++; $display("FAIL abort_immediate: nCS,SCLK,busy,done=%b required 1000",
                               {nCS, SCLK, busy, done});
        end
        repeat (3) @(posedge clk_16mhz);
        @(negedge clk_16mhz);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_16mhz);
        #1;
        n_checks++;
        if (done_cnt !== done0 || rxv_cnt !== rxv0) begin
            n_fail++; $display("FAIL abort_no_pulses: done=%0d rx_valid=%0d required 0 0",
                               done_cnt - done0, rxv_cnt - rxv0);
        end
        run_txn(8'h0A, 8'h2D, 8'h01, 8'h55, -1);
        n_checks++;
        if (r_len !== 204 || bus_q.size() !== 3 || bus_q[1] !== 8'h2D || s_wr_data !== 8'h55) begin
            n_fail++; $display("FAIL abort_recover: len=%0d bytes=%p wr=%h required 204 0a 2d 55 wr=55",
                               r_len, bus_q, s_wr_data);
        end
    endtask

    task automatic test_zero_length();
        run_txn(8'h0B, 8'h1E, 8'h00, 8'h00, -1);
        n_checks++;
        if (r_len !== 139) begin
            n_fail++; $display("FAIL zero_length: got %0d cycles required 139", r_len);
        end
        n_checks++;
        if (bus_q.size() !== 2 || bus_q[0] !== 8'h0B || bus_q[1] !== 8'h1E) begin
            n_fail++; $display("FAIL zero_bytes: got %p required 0b 1e", bus_q);
        end
        n_checks++;
        if (r_ack !== 0 || r_rxv !== 0 || r_done !== 1) begin
            n_fail++; $display("FAIL zero_pulses: tx_ack=%0d rx_valid=%0d done=%0d required 0 0 1",
                               r_ack, r_rxv, r_done);
        end
    endtask

    task automatic test_sclk_gated();
        n_checks++;
        if (sclk_bad_cnt !== 0) begin
            n_fail++; $display("FAIL sclk_with_ncs_high: got %0d samples required 0", sclk_bad_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hAD;
        mem[8'h0E] = 8'h11; mem[8'h0F] = 8'h22; mem[8'h10] = 8'h33;
        mem[8'h11] = 8'h44; mem[8'h12] = 8'h55; mem[8'h13] = 8'h66;

        test_reset();
        test_register_write();
        test_single_read();
        test_burst_read();
        test_busy_reject();
        test_reset_mid();
        test_zero_length();
        test_sclk_gated();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
